vga_timing_ctrl: RTL



---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing_ctrl_if.sv | 29 ++
 rtl/vga_delay_line.sv | 39 +++
 rtl/vga_timing_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults and phase type for the VGA pixel-timing controller.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    typedef enum logic [1:0] {
        ACTIVE,
        FP,
        SYNC,
        BP
    } vga_phase_t;

    // Eight 80-pixel colour bars; bar index bits map to {R,G,B}.
    function automatic logic [23:0] bar_rgb(input logic [9:0] x);
        logic [2:0] idx;
        idx = 3'(x / 10'd80);
        return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Bundle of the pixel-source fetch path and the DAC output path of vga_timing_ctrl.
interface vga_timing_ctrl_if;
    logic       req;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       vga_sync_n;

    modport master (
        output req, x, y, frame_start,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
        input  r, g, b
    );

    modport slave (
        input  req, x, y, frame_start,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
        output r, g, b
    );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a per-bit asynchronous reset value; depth 0 is a wire.
module vga_delay_line #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    if (DEPTH == 0) begin : g_bypass
        assign o_q = i_d;
    end else begin : g_shift
        logic [W-1:0] stage_q [DEPTH];
        logic [W-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d[0] = i_d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= RST_VAL;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign o_q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan counters, sync generation and RGB realignment for a fixed-latency pixel source.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIX_LAT  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       i_test,
`endif
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
    output logic       o_req,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_frame_start,
    output logic [7:0] o_vga_r,
    output logic [7:0] o_vga_g,
    output logic [7:0] o_vga_b,
    output logic       o_vga_hs,
    output logic       o_vga_vs,
    output logic       o_vga_blank_n,
    output logic       o_vga_sync_n
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_BP_START   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_BP_START   = V_SYNC_START + V_SYNC;

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       h_wrap;
    vga_phase_t hphase_q, hphase_d;
    vga_phase_t vphase_q, vphase_d;

    always_comb begin
        h_wrap = (h_q == 10'(H_TOTAL - 1));
        h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == 10'(V_TOTAL - 1)) ? 10'd0 : v_q + 10'd1;
        end
    end

    // Phase states track the counter value they will be registered alongside.
    always_comb begin
        hphase_d = hphase_q;
        case (hphase_q)
            ACTIVE:  if (h_d == 10'(H_ACTIVE))     hphase_d = FP;
            FP:      if (h_d == 10'(H_SYNC_START)) hphase_d = SYNC;
            SYNC:    if (h_d == 10'(H_BP_START))   hphase_d = BP;
            BP:      if (h_d == 10'd0)             hphase_d = ACTIVE;
            default: hphase_d = ACTIVE;
        endcase

        vphase_d = vphase_q;
        if (h_wrap) begin
            case (vphase_q)
                ACTIVE:  if (v_d == 10'(V_ACTIVE))     vphase_d = FP;
                FP:      if (v_d == 10'(V_SYNC_START)) vphase_d = SYNC;
                SYNC:    if (v_d == 10'(V_BP_START))   vphase_d = BP;
                BP:      if (v_d == 10'd0)             vphase_d = ACTIVE;
                default: vphase_d = ACTIVE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_q      <= 10'd0;
            v_q      <= 10'd0;
            hphase_q <= ACTIVE;
            vphase_q <= ACTIVE;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            hphase_q <= hphase_d;
            vphase_q <= vphase_d;
        end
    end

    logic hs_raw, vs_raw, blank_raw;

    assign o_x           = h_q;
    assign o_y           = v_q;
    assign o_req         = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
    assign o_frame_start = (h_q == 10'd0) && (v_q == 10'd0);
    assign hs_raw        = (hphase_q != SYNC);
    assign vs_raw        = (vphase_q != SYNC);
    assign blank_raw     = o_req;

    // Controls travel PIX_LAT cycles so they meet the returned pixel.
`ifdef VGA_TEST_PATTERN_EN
    localparam int              DL_W   = 13;
    localparam logic [DL_W-1:0] DL_RST = {3'b110, 10'd0};
    logic [9:0] x_dly;
`else
    localparam int              DL_W   = 3;
    localparam logic [DL_W-1:0] DL_RST = 3'b110;
`endif

    logic [DL_W-1:0] dl_in, dl_out;
    logic            hs_dly, vs_dly, blank_dly;

`ifdef VGA_TEST_PATTERN_EN
    assign dl_in = {hs_raw, vs_raw, blank_raw, h_q};
    assign {hs_dly, vs_dly, blank_dly, x_dly} = dl_out;
`else
    assign dl_in = {hs_raw, vs_raw, blank_raw};
    assign {hs_dly, vs_dly, blank_dly} = dl_out;
`endif

    vga_delay_line #(
        .W       (DL_W),
        .DEPTH   (PIX_LAT),
        .RST_VAL (DL_RST)
    ) u_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (dl_in),
        .o_q     (dl_out)
    );

    logic        vga_hs_q, vga_hs_d;
    logic        vga_vs_q, vga_vs_d;
    logic        vga_blank_n_q, vga_blank_n_d;
    logic [23:0] vga_rgb_q, vga_rgb_d;

    // Blanked pixels are forced black whatever the source returns.
    always_comb begin
        vga_hs_d      = hs_dly;
        vga_vs_d      = vs_dly;
        vga_blank_n_d = blank_dly;
        vga_rgb_d     = 24'd0;
        if (blank_dly) begin
`ifdef VGA_TEST_PATTERN_EN
            vga_rgb_d = i_test ? bar_rgb(x_dly) : {i_r, i_g, i_b};
`else
            vga_rgb_d = {i_r, i_g, i_b};
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            vga_blank_n_q <= 1'b0;
            vga_rgb_q     <= 24'd0;
        end else begin
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            vga_blank_n_q <= vga_blank_n_d;
            vga_rgb_q     <= vga_rgb_d;
        end
    end

    assign o_vga_hs      = vga_hs_q;
    assign o_vga_vs      = vga_vs_q;
    assign o_vga_blank_n = vga_blank_n_q;
    assign {o_vga_r, o_vga_g, o_vga_b} = vga_rgb_q;
    assign o_vga_sync_n  = 1'b0;

endmodule
